// File: rtl/ir_pkg.sv
// Shared definitions for the instruction queue.
// Contents: default word/opcode/depth constants, operand-width helper, and the
// packed instr_t view {opcode, operand} of a default-sized instruction word.
package ir_pkg;

  localparam int unsigned IQ_INSTR_W = 8;
  localparam int unsigned IQ_OPC_W   = 4;
  localparam int unsigned IQ_DEPTH   = 4;

  // Operand occupies whatever the opcode leaves in the low bits.
  function automatic int unsigned operand_w(input int unsigned instr_w,
                                            input int unsigned opc_w);
    return instr_w - opc_w;
  endfunction

  typedef struct packed {
    logic [IQ_OPC_W-1:0]            opcode;
    logic [IQ_INSTR_W-IQ_OPC_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/iq_mem.sv
// Storage array for the instruction queue.
// DEPTH x INSTR_W words, synchronous write, asynchronous read, cleared on reset.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   i_we         - write enable
//   i_waddr      - write address
//   i_wdata      - write data
//   i_raddr      - read address
//   o_rdata      - read data (combinational from i_raddr)
module iq_mem #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [INSTR_W-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [INSTR_W-1:0]         o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue between fetch and decode: a small FIFO with flush.
// Optional feature macro: IQ_BYPASS_EN -- when defined, an empty queue passes
// instr_in straight to the decoder outputs in the same cycle.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   fetch_valid/ready     - push handshake, instr_in is the pushed word
//   dec_valid/ready       - pop handshake, opcode/operand show the head word
//   flush                 - discard all entries at the next edge
//   count                 - current occupancy
module instruction_queue
  import ir_pkg::*;
#(
  parameter int unsigned INSTR_W = IQ_INSTR_W,
  parameter int unsigned OPC_W   = IQ_OPC_W,
  parameter int unsigned DEPTH   = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [OPC_W-1:0]           opcode,
  output logic [INSTR_W-OPC_W-1:0]   operand,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned OPR_W = operand_w(INSTR_W, OPC_W);

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_byp;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_rdata;
  logic [INSTR_W-1:0] w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IQ_BYPASS_EN
  assign w_byp  = w_empty && fetch_valid;
  assign w_head = w_empty ? instr_in : w_rdata;
`else
  assign w_byp  = 1'b0;
  assign w_head = w_rdata;
`endif

  // fetch_ready depends on state only, so a full queue never accepts a push
  // alongside a pop.
  assign fetch_ready = !w_full;
  assign dec_valid   = !w_empty || w_byp;
  assign w_pop       = !w_empty && dec_ready;
  // A bypassed word consumed this cycle is never written.
  assign w_push      = fetch_valid && !w_full && !(w_byp && dec_ready);

  iq_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_push && !flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (instr_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are AW bits wide, so increments wrap modulo DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign opcode  = dec_valid ? w_head[INSTR_W-1 -: OPC_W] : '0;
  assign operand = dec_valid ? w_head[OPR_W-1:0]          : '0;
  assign count   = r_count;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue with a queue-based scoreboard.
module tb_instruction_queue;
  import ir_pkg::*;

  localparam int unsigned DEPTH = IQ_DEPTH;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       fetch_valid = 1'b0;
  logic       dec_ready   = 1'b0;
  logic       flush       = 1'b0;
  logic [7:0] instr_in    = 8'h00;
  logic       fetch_ready;
  logic       dec_valid;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [2:0] count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];
  logic       exp_v;
  logic [7:0] exp_w;
  instr_t     exp_i;

  instruction_queue dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .instr_in    (instr_in),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .opcode      (opcode),
    .operand     (operand),
    .flush       (flush),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one clock edge, applied to the scoreboard.
  task automatic model_edge();
    int  n;
    bit  pop;
    bit  push;
    n = sb.size();
    if (reset || flush) begin
      sb.delete();
    end else begin
      pop  = dec_ready && (n != 0 || (BYP && fetch_valid));
      push = fetch_valid && (n != DEPTH);
      if (push) sb.push_back(instr_in);
      if (pop)  void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Expected decoder-side view for the current inputs and scoreboard.
  task automatic calc_exp();
    exp_v = (sb.size() != 0) || (BYP && fetch_valid);
    exp_w = (sb.size() != 0) ? sb[0] : (exp_v ? instr_in : 8'h00);
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", count);
    end
    n_tests++;
    if (dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", dec_valid, fetch_ready);
    end
    n_tests++;
    if ({opcode, operand} !== 8'h00) begin
      n_fail++; $display("FAIL reset_head: got %h want 00", {opcode, operand});
    end
    @(negedge clk);
    reset = 1'b0;
    // Pop while empty must be ignored.
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_pop: got count=%0d v=%b want 0 0", count, dec_valid);
    end
  endtask

  task automatic test_fill();
    logic [7:0] words[4];
    words = '{8'h3A, 8'h5C, 8'h7E, 8'h91};
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1;
      instr_in    = words[i];
      #2;
      n_tests++;
      if (count !== 3'(sb.size())) begin
        n_fail++; $display("FAIL fill_count: got %0d want %0d", count, sb.size());
      end
      tick();
    end
    fetch_valid = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd4 || fetch_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state: got count=%0d r=%b want 4 0", count, fetch_ready);
    end
    // Fifth push must be ignored.
    fetch_valid = 1'b1;
    instr_in    = 8'hFF;
    tick();
    fetch_valid = 1'b0;
    #2;
    exp_i = instr_t'(sb[0]);
    n_tests++;
    if (count !== 3'd4 || opcode !== exp_i.opcode || operand !== exp_i.operand) begin
      n_fail++;
      $display("FAIL full_push: got count=%0d op=%h opr=%h want 4 %h %h",
               count, opcode, operand, exp_i.opcode, exp_i.operand);
    end
    n_tests++;
    if (opcode !== 4'h3 || operand !== 4'hA) begin
      n_fail++; $display("FAIL full_head: got %h%h want 3A", opcode, operand);
    end
  endtask

  task automatic test_full_drain();
    fetch_valid = 1'b1;
    dec_ready   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr_in = 8'hC0 + 8'(i);
      #2;
      calc_exp();
      n_tests++;
      if (fetch_ready !== (sb.size() != DEPTH) || count !== 3'(sb.size())) begin
        n_fail++;
        $display("FAIL fd_hs: got r=%b count=%0d want r=%b count=%0d",
                 fetch_ready, count, sb.size() != DEPTH, sb.size());
      end
      n_tests++;
      if (dec_valid !== exp_v || {opcode, operand} !== exp_w) begin
        n_fail++;
        $display("FAIL fd_head: got v=%b %h want v=%b %h", dec_valid, {opcode, operand}, exp_v,
                 exp_w);
      end
      tick();
    end
    fetch_valid = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      #2;
      calc_exp();
      n_tests++;
      if (dec_valid !== exp_v || {opcode, operand} !== exp_w) begin
        n_fail++;
        $display("FAIL drain_head: got v=%b %h want v=%b %h", dec_valid, {opcode, operand},
                 exp_v, exp_w);
      end
      tick();
    end
    dec_ready = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_end: got count=%0d v=%b want 0 0", count, dec_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = 8'h20 + 8'(i);
      tick();
    end
    instr_in = 8'h55;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || opcode !== 4'h0 || fetch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got count=%0d v=%b op=%h r=%b want 0 0 0 1",
               count, dec_valid, opcode, fetch_ready);
    end
    sb.delete();
    fetch_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Resume: a push is visible one cycle later.
    fetch_valid = 1'b1;
    instr_in    = 8'h66;
    #2;
    calc_exp();
    n_tests++;
    if (dec_valid !== exp_v) begin
      n_fail++; $display("FAIL resume_pre: got v=%b want %b", dec_valid, exp_v);
    end
    tick();
    fetch_valid = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd1 || dec_valid !== 1'b1 || {opcode, operand} !== 8'h66) begin
      n_fail++;
      $display("FAIL resume_post: got count=%0d v=%b %h want 1 1 66", count, dec_valid,
               {opcode, operand});
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_wrap();
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    instr_in    = 8'h10;
    tick();
    dec_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      instr_in = 8'h10 + 8'(i);
      #2;
      calc_exp();
      n_tests++;
      if (count !== 3'd1 || {opcode, operand} !== exp_w) begin
        n_fail++;
        $display("FAIL wrap_%0d: got count=%0d %h want 1 %h", i, count, {opcode, operand}, exp_w);
      end
      tick();
    end
    fetch_valid = 1'b0;
    #2;
    n_tests++;
    if ({opcode, operand} !== 8'h1A) begin
      n_fail++; $display("FAIL wrap_last: got %h want 1A", {opcode, operand});
    end
    tick();
    dec_ready = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL wrap_empty: got %0d want 0", count);
    end
  endtask

  task automatic test_flush();
    dec_ready   = 1'b0;
    fetch_valid = 1'b1;
    instr_in    = 8'h11;
    tick();
    instr_in = 8'h22;
    tick();
    instr_in = 8'h42;
    flush    = 1'b1;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got count=%0d v=%b want 0 0", count, dec_valid);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({opcode, operand} !== 8'h00 || dec_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak: got v=%b %h want v=0 00", dec_valid,
                           {opcode, operand});
      end
      tick();
      #2;
    end
  endtask

`ifdef IQ_BYPASS_EN
  task automatic test_bypass();
    fetch_valid = 1'b1;
    dec_ready   = 1'b1;
    instr_in    = 8'hB4;
    #2;
    n_tests++;
    if (dec_valid !== 1'b1 || opcode !== 4'hB || operand !== 4'h4 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL bypass_same: got v=%b op=%h opr=%h count=%0d want 1 B 4 0",
               dec_valid, opcode, operand, count);
    end
    tick();
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    #2;
    n_tests++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_after: got count=%0d v=%b want 0 0", count, dec_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full_drain();
    test_reset_mid_burst();
    test_wrap();
    test_flush();
`ifdef IQ_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter INSTR_W, default 8: instruction word width in bits.
REQ-002 SHALL have parameter OPC_W, default 4: opcode field width, taken from MSBs; operand width is INSTR_W-OPC_W.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; legal values are powers of two >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fetch_valid  input  1  fetch side presents instr_in.
REQ-007 SHALL have port fetch_ready  output  1  queue can accept a word this cycle.
REQ-008 SHALL have port instr_in  input  INSTR_W  fetched instruction word.
REQ-009 SHALL have port dec_valid  output  1  head entry is valid for the decoder.
REQ-010 SHALL have port dec_ready  input  1  decoder consumes the head this cycle.
REQ-011 SHALL have port opcode  output  OPC_W  head word bits [INSTR_W-1:INSTR_W-OPC_W].
REQ-012 SHALL have port operand  output  INSTR_W-OPC_W  head word low bits.
REQ-013 SHALL have port flush  input  1  discard all queued entries (branch or jump).
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL be a FIFO: push when fetch_valid && fetch_ready; pop when dec_valid && dec_ready.
REQ-016 SHALL drive fetch_ready = (count != DEPTH), with no combinational dependency on dec_ready; a full queue SHALL NOT accept a push in the same cycle as a pop.
REQ-017 SHALL drive dec_valid = (count != 0) (without bypass, see REQ-026).
REQ-018 SHALL give a pushed word 1-cycle latency: it is visible at the head the cycle after the push.
REQ-019 SHALL leave count unchanged on simultaneous push and pop; otherwise count SHALL change by +1 or -1.
REQ-020 SHALL wrap read and write pointers modulo DEPTH, with no bubble at the wrap boundary.
REQ-021 SHALL drive opcode and operand to 0 whenever dec_valid=0.
REQ-022 SHALL, on flush, set count and both pointers to 0 at the next edge. flush takes priority: a same-cycle push is dropped, and a same-cycle pop has no additional effect.
REQ-023 SHALL ignore a pop while empty and a push while full; no state change results from either.

Reset
REQ-024 SHALL, while reset=1 and independent of clk, force count=0, pointers=0, storage=0, dec_valid=0, opcode=0, operand=0, fetch_ready=1.
REQ-025 SHALL discard any in-flight push or pop when reset asserts mid-operation, and SHALL resume normally on the first edge after reset deasserts.

Configuration
REQ-026 SHALL support macro IQ_BYPASS_EN. When defined and the queue is empty, fetch_valid=1 SHALL drive dec_valid=1 with opcode/operand taken combinationally from instr_in. If dec_ready=1 in that cycle, the word SHALL be consumed without being stored and count SHALL stay 0. Otherwise the word SHALL be stored normally.
REQ-027 SHALL, when IQ_BYPASS_EN is undefined, build no bypass path and have no combinational path from instr_in to opcode/operand; latency is REQ-018.

Structure
REQ-028 SHALL place in shared package ir_pkg: default INSTR_W/OPC_W/DEPTH constants, operand width function, and a packed instr_t typedef {opcode, operand}.
REQ-029 SHALL place storage in sub-module iq_mem: DEPTH x INSTR_W array with synchronous write and asynchronous read, cleared on reset.
REQ-030 SHALL keep pointer, count and handshake control in instruction_queue itself.

Verification
REQ-031 SHALL cover: reset mid-burst with 3 entries queued -> count=0, dec_valid=0, opcode=0, fetch_ready=1 immediately.
REQ-032 SHALL cover: push 0x3A, 0x5C, 0x7E, 0x91 with dec_ready=0 -> count=4, fetch_ready=0; a 5th push 0xFF is ignored; the head is opcode=3, operand=A.
REQ-033 SHALL cover: full queue with fetch_valid and dec_ready both held -> pops proceed while fetch_ready=0; fill and drain resume without loss, in order 3A,5C,7E,91.
REQ-034 SHALL cover: 10 consecutive pushes and pops with DEPTH=4 -> pointers wrap twice, output order equals input order, count stays 1 at steady state.
REQ-035 SHALL cover: flush asserted together with a push of 0x42 while count=2 -> next cycle count=0, dec_valid=0, and 0x42 never appears.
REQ-036 SHALL cover: with IQ_BYPASS_EN, empty queue, push 0xB4 with dec_ready=1 -> same cycle dec_valid=1, opcode=B, operand=4; count remains 0.
